// File: rtl/mips_pkg.sv
// Shared fetch-side types: FSM state encoding, reset/IMEM defaults, NOP.
// Also a range-check helper used by the fetch sequencer.
package mips_pkg;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_3000;
  localparam logic [31:0] IMEM_BASE_DEF = 32'h0000_3000;
  localparam int unsigned IMEM_WORDS_DEF = 1024;
  localparam logic [31:0] NOP = 32'h0000_0000;

  // Unsigned check: base <= a < base + 4*words.
  function automatic logic in_imem(
    input logic [31:0] a,
    input logic [31:0] base,
    input int unsigned words
  );
    logic [31:0] lim;
    lim = base + (words << 2);
    return (a >= base) && (a < lim);
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// PC register + IMEM fetch sequencer (req/gnt/rvalid) feeding decode/NPC.
// Ports: clk, reset_n, npc, stall, imem_*, pc, instr, instr_valid, fetch_err.
// Option: FETCH_ALIGN_CHECK_EN traps a misaligned npc at retire.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0] IMEM_BASE  = IMEM_BASE_DEF,
  parameter int unsigned IMEM_WORDS = IMEM_WORDS_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] npc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         instr_valid_q, instr_valid_d;
  logic         imem_req_q, imem_req_d;
  logic         fetch_err_q, fetch_err_d;

  logic [31:0]  pc_ld;
  logic         retire;
  logic         pc_ok;

  assign pc_ld  = {npc[31:2], 2'b00};
  assign retire = instr_valid_q && !stall;
  assign pc_ok  = in_imem(pc_q, IMEM_BASE, IMEM_WORDS);

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    imem_req_d    = imem_req_q;
    fetch_err_d   = fetch_err_q;

    unique case (state_q)
      S_BOOT: begin
        // req is registered, so it is
        // raised on entry to S_REQ only
        // when that PC is fetchable.
        state_d    = S_REQ;
        imem_req_d = pc_ok;
      end

      S_REQ: begin
        if (!pc_ok) begin
          imem_req_d  = 1'b0;
          fetch_err_d = 1'b1;
          instr_d     = NOP;
          state_d     = S_ERR;
        end else if (imem_gnt) begin
          imem_req_d = 1'b0;
          if (imem_rvalid) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = S_DONE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end

      S_WAIT: begin
        imem_req_d = 1'b0;
        if (imem_rvalid) begin
          instr_d       = imem_rdata;
          instr_valid_d = 1'b1;
          state_d       = S_DONE;
        end
      end

      S_DONE: begin
        if (retire) begin
`ifdef FETCH_ALIGN_CHECK_EN
          if (npc[1:0] != 2'b00) begin
            fetch_err_d   = 1'b1;
            instr_valid_d = 1'b0;
            instr_d       = NOP;
            imem_req_d    = 1'b0;
            state_d       = S_ERR;
          end else begin
            pc_d          = pc_ld;
            instr_valid_d = 1'b0;
            imem_req_d    = in_imem(pc_ld, IMEM_BASE, IMEM_WORDS);
            state_d       = S_REQ;
          end
`else
          pc_d          = pc_ld;
          instr_valid_d = 1'b0;
          imem_req_d    = in_imem(pc_ld, IMEM_BASE, IMEM_WORDS);
          state_d       = S_REQ;
`endif
        end
      end

      S_ERR: begin
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end

      default: begin
        state_d       = S_ERR;
        fetch_err_d   = 1'b1;
        imem_req_d    = 1'b0;
        instr_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_BOOT;
      pc_q          <= RESET_PC;
      instr_q       <= NOP;
      instr_valid_q <= 1'b0;
      imem_req_q    <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      imem_req_q    <= imem_req_d;
      fetch_err_q   <= fetch_err_d;
    end
  end

  assign imem_req    = imem_req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, latencies, stall, range and
// alignment faults, reset mid-fetch.
module tb_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [31:0] npc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_err;

  int n_vec;
  int n_bad;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .npc         (npc),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_bad       = 0;
    reset_n     = 1'b0;
    npc         = 32'h0;
    stall       = 1'b0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;

    // reset state
    step();
    step();
    chk("rst_pc", pc, 32'h0000_3000);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_err", {31'b0, fetch_err}, 32'd0);

    // boot, zero-latency memory
    reset_n = 1'b1;
    step();  // BOOT -> REQ
    chk("z_req", {31'b0, imem_req}, 32'd1);
    chk("z_addr", imem_addr, 32'h0000_3000);
    chk("z_valid0", {31'b0, instr_valid}, 32'd0);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2008_0005;
    npc         = 32'h0000_3004;
    stall       = 1'b1;
    step();  // REQ -> DONE
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    chk("z_valid1", {31'b0, instr_valid}, 32'd1);
    chk("z_instr", instr, 32'h2008_0005);
    chk("z_pc_hold", pc, 32'h0000_3000);
    chk("z_req_lo", {31'b0, imem_req}, 32'd0);
    stall = 1'b0;
    step();  // retire
    chk("z_pc_new", pc, 32'h0000_3004);
    chk("z_valid_lo", {31'b0, instr_valid}, 32'd0);
    chk("z_req2", {31'b0, imem_req}, 32'd1);

    // 1-cycle memory, three sequential fetches
    for (int k = 0; k < 3; k++) begin
      chk("l_addr", imem_addr, 32'h0000_3004 + 32'(4 * k));
      chk("l_req", {31'b0, imem_req}, 32'd1);
      imem_gnt = 1'b1;
      step();  // REQ -> WAIT
      imem_gnt = 1'b0;
      chk("l_wait_req", {31'b0, imem_req}, 32'd0);
      chk("l_wait_v", {31'b0, instr_valid}, 32'd0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hA000_0000 + 32'(k);
      step();  // WAIT -> DONE
      imem_rvalid = 1'b0;
      chk("l_valid", {31'b0, instr_valid}, 32'd1);
      chk("l_instr", instr, 32'hA000_0000 + 32'(k));
      npc = 32'h0000_3008 + 32'(4 * k);
      step();  // retire -> REQ
      chk("l_pc", pc, 32'h0000_3008 + 32'(4 * k));
      chk("l_v_lo", {31'b0, instr_valid}, 32'd0);
    end

    // stall in DONE
    chk("s_pc0", pc, 32'h0000_3010);
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h1234_5678;
    stall       = 1'b1;
    npc         = 32'h0000_3040;
    step();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("s_pc", pc, 32'h0000_3010);
      chk("s_instr", instr, 32'h1234_5678);
      chk("s_valid", {31'b0, instr_valid}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("s_pc_new", pc, 32'h0000_3040);

    // out-of-range npc
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0BAD_0001;
    npc         = 32'h0000_2FFC;
    step();  // DONE
    imem_rvalid = 1'b0;
    step();  // retire to 2FFC, gnt still high
    chk("r_pc", pc, 32'h0000_2FFC);
    chk("r_req0", {31'b0, imem_req}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("r_err", {31'b0, fetch_err}, 32'd1);
      chk("r_req", {31'b0, imem_req}, 32'd0);
      chk("r_instr", instr, 32'h0);
      chk("r_valid", {31'b0, instr_valid}, 32'd0);
      chk("r_pc_frz", pc, 32'h0000_2FFC);
    end
    imem_gnt = 1'b0;

    // reset mid-WAIT, late rvalid
    reset_n = 1'b0;
    step();
    chk("m_err_clr", {31'b0, fetch_err}, 32'd0);
    reset_n = 1'b1;
    step();  // REQ
    imem_gnt = 1'b1;
    step();  // WAIT
    imem_gnt = 1'b0;
    chk("m_wait_req", {31'b0, imem_req}, 32'd0);
    reset_n     = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hDEAD_BEEF;
    #1;
    chk("m_rst_instr", instr, 32'h0);
    step();
    chk("m_rst_instr2", instr, 32'h0);
    reset_n = 1'b1;
    step();  // BOOT -> REQ, rvalid ignored
    chk("m_boot_instr", instr, 32'h0);
    chk("m_boot_valid", {31'b0, instr_valid}, 32'd0);
    chk("m_restart", imem_addr, 32'h0000_3000);
    chk("m_req", {31'b0, imem_req}, 32'd1);
    imem_rvalid = 1'b0;
    step();  // no gnt: stay in REQ
    chk("m_req_hold", {31'b0, imem_req}, 32'd1);
    chk("m_valid_hold", {31'b0, instr_valid}, 32'd0);

    // misaligned npc
    imem_gnt    = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h2008_0005;
    npc         = 32'h0000_3006;
    step();  // DONE
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    chk("a_valid", {31'b0, instr_valid}, 32'd1);
    step();  // retire
`ifdef FETCH_ALIGN_CHECK_EN
    chk("a_err", {31'b0, fetch_err}, 32'd1);
    chk("a_pc", pc, 32'h0000_3000);
    chk("a_req", {31'b0, imem_req}, 32'd0);
    chk("a_v", {31'b0, instr_valid}, 32'd0);
`else
    chk("a_err", {31'b0, fetch_err}, 32'd0);
    chk("a_pc", pc, 32'h0000_3004);
    chk("a_req", {31'b0, imem_req}, 32'd1);
    chk("a_addr", imem_addr, 32'h0000_3004);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
